// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SPI-mode SD command framer and R1/R3/R7 collector.
// Ports: cmd_* request handshake, rsp_* result, sd_* SPI pins; define SD_SPI_CRC7_EN for live CRC7.
module sd_spi_cmd_engine #(
  parameter int CLK_DIV_SLOW = 250,
  parameter int CLK_DIV_FAST = 4,
  parameter int R1_POLL_MAX  = 8,
  parameter int DUMMY_BYTES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_long,
  input  logic        cmd_dummy,
  input  logic        fast_clk,
  output logic        rsp_valid,
  output logic [7:0]  rsp_r1,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        sd_cclk,
  output logic        sd_cmd,
  input  logic        sd_data,
  output logic        sd_cs
);

  localparam int DMAX =
    (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int DW = (DMAX > 2) ? $clog2(DMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, DUMMY, PRE, CMD, POLL, DATA, POST, DONE
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_max;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic [7:0]    tx;
  logic [7:0]    rx;
  logic [7:0]    nxt_byte;
  logic [7:0]    cmd_byte;
  logic [7:0]    crc_byte;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic          long_q;
  logic          accept;
  logic          active;
  logic          half;
  logic          bit_tick;
  logic          byte_end;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign active    = (state != IDLE) && (state != DONE);
  assign half      = active && (div_cnt == (div_max >> 1));
  assign bit_tick  = active && (div_cnt == div_max);
  assign byte_end  = bit_tick && (bit_cnt == 3'd7);
  assign sd_cmd    = tx[7];

`ifdef SD_SPI_CRC7_EN
  logic [6:0] crc;
  logic [6:0] crc_n;
  // next CRC including the bit currently on MOSI
  assign crc_n = {crc[5:0], 1'b0}
               ^ ((crc[6] ^ tx[7]) ? 7'h09 : 7'h00);
  assign crc_byte = {crc_n, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (accept) begin
      crc <= '0;
    end else if (bit_tick && state == CMD
                 && byte_cnt < 4'd5) begin
      crc <= crc_n;
    end
  end
`else
  assign crc_byte = (idx_q == 6'd0) ? 8'h95 :
                    (idx_q == 6'd8) ? 8'h87 : 8'h01;
`endif

  // byte loaded when CMD byte byte_cnt finishes
  always_comb begin
    cmd_byte = 8'hFF;
    case (byte_cnt)
      4'd0:    cmd_byte = arg_q[31:24];
      4'd1:    cmd_byte = arg_q[23:16];
      4'd2:    cmd_byte = arg_q[15:8];
      4'd3:    cmd_byte = arg_q[7:0];
      4'd4:    cmd_byte = crc_byte;
      default: cmd_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_n  = state;
    nxt_byte = 8'hFF;
    unique case (state)
      IDLE:
        if (accept) state_n = cmd_dummy ? DUMMY : PRE;
      DUMMY:
        if (byte_end && byte_cnt == 4'(DUMMY_BYTES - 1))
          state_n = DONE;
      PRE:
        if (byte_end) begin
          state_n  = CMD;
          nxt_byte = {2'b01, idx_q};
        end
      CMD:
        if (byte_end) begin
          if (byte_cnt == 4'd5) state_n = POLL;
          else nxt_byte = cmd_byte;
        end
      POLL:
        if (byte_end) begin
          if (!rx[7]) state_n = long_q ? DATA : POST;
          else if (byte_cnt == 4'(R1_POLL_MAX - 1))
            state_n = POST;
        end
      DATA:
        if (byte_end && byte_cnt == 4'd3) state_n = POST;
      POST:
        if (byte_end) state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      div_max     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      tx          <= 8'hFF;
      rx          <= 8'hFF;
      idx_q       <= '0;
      arg_q       <= '0;
      long_q      <= 1'b0;
      sd_cclk     <= 1'b0;
      sd_cs       <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_r1      <= 8'hFF;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      rsp_valid <= (state == DONE);
      if (accept) begin
        div_max <= fast_clk ? DW'(CLK_DIV_FAST - 1)
                            : DW'(CLK_DIV_SLOW - 1);
        div_cnt     <= '0;
        bit_cnt     <= '0;
        byte_cnt    <= '0;
        tx          <= 8'hFF;
        sd_cs       <= cmd_dummy;
        idx_q       <= cmd_index;
        arg_q       <= cmd_arg;
        long_q      <= cmd_long && !cmd_dummy;
        rsp_timeout <= 1'b0;
        rsp_data    <= '0;
        if (cmd_dummy) rsp_r1 <= 8'hFF;
      end else if (active) begin
        if (half) begin
          sd_cclk <= 1'b1;
          rx      <= {rx[6:0], sd_data};
        end
        if (bit_tick) begin
          div_cnt <= '0;
          sd_cclk <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          tx <= byte_end ? nxt_byte : {tx[6:0], 1'b1};
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        if (byte_end) begin
          byte_cnt <= (state_n != state) ? 4'd0
                                         : byte_cnt + 4'd1;
          // CS rises together with the cclk-low edge
          if (state_n == POST) sd_cs <= 1'b1;
          if (state == POLL) begin
            if (!rx[7]) begin
              rsp_r1 <= rx;
            end else if (state_n == POST) begin
              rsp_timeout <= 1'b1;
              rsp_r1      <= 8'hFF;
            end
          end
          if (state == DATA)
            rsp_data <= {rsp_data[23:0], rx};
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine: table + random checks of the SD SPI command engine.
// A byte-level card model answers on MISO; expectations come from protocol rules.
module tb_sd_spi_cmd_engine;

  localparam int DS   = 250;
  localparam int DF   = 4;
  localparam int PMAX = 8;
  localparam int NDUM = 10;

`ifdef SD_SPI_CRC7_EN
  localparam logic [7:0] CRC55 = 8'h65;
  localparam logic [7:0] CRC41 = 8'h77;
`else
  localparam logic [7:0] CRC55 = 8'h01;
  localparam logic [7:0] CRC41 = 8'h01;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_long;
  logic        cmd_dummy;
  logic        fast_clk;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        sd_cclk;
  logic        sd_cmd;
  logic        sd_data;
  logic        sd_cs;

  always #5 clk = ~clk;

  sd_spi_cmd_engine #(
    .CLK_DIV_SLOW(DS),
    .CLK_DIV_FAST(DF),
    .R1_POLL_MAX (PMAX),
    .DUMMY_BYTES (NDUM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .cmd_long   (cmd_long),
    .cmd_dummy  (cmd_dummy),
    .fast_clk   (fast_clk),
    .rsp_valid  (rsp_valid),
    .rsp_r1     (rsp_r1),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .sd_cclk    (sd_cclk),
    .sd_cmd     (sd_cmd),
    .sd_data    (sd_data),
    .sd_cs      (sd_cs)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // card model: bytes after the 7 request bytes come from resp[]
  logic [7:0] resp [16];
  int         resp_len = 0;
  int         nbits = 0;
  logic       mosi_bits [$];
  logic       cs_bits [$];

  function automatic logic card_bit(input int n);
    int b;
    b = n / 8;
    if (b >= 7 && (b - 7) < resp_len)
      return resp[b - 7][7 - (n % 8)];
    return 1'b1;
  endfunction

  always @(posedge sd_cclk) begin
    mosi_bits.push_back(sd_cmd);
    cs_bits.push_back(sd_cs);
    nbits++;
  end

  always @(negedge sd_cclk) sd_data = card_bit(nbits);

  function automatic logic [7:0] exp_crc(input logic [5:0] idx,
                                         input logic [31:0] arg);
`ifdef SD_SPI_CRC7_EN
    logic [39:0] m;
    logic [6:0]  c;
    logic        fb;
    m = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ m[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
`else
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return arg[7:0] & 8'h00 | 8'h01;
`endif
  endfunction

  task automatic start_txn(input logic dummy, input logic [5:0] idx,
                           input logic [31:0] arg, input logic lng,
                           input logic fast);
    @(negedge clk);
    check("ready_before", cmd_ready, 1);
    mosi_bits.delete();
    cs_bits.delete();
    nbits     = 0;
    sd_data   = 1'b1;
    cmd_valid = 1'b1;
    cmd_dummy = dummy;
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_long  = lng;
    fast_clk  = fast;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    fast_clk  = ~fast;
    cmd_long  = ~lng;
    cmd_index = 6'($urandom);
    check("ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60000; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic after_rsp(input string tag);
    check({tag, "_ready_in_pulse"}, cmd_ready, 0);
    @(posedge clk);
    #1;
    check({tag, "_pulse_len"}, rsp_valid, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx,
                         input logic [31:0] arg, input logic lng,
                         input logic fast, input int nrsp,
                         input logic [127:0] rb,
                         input logic [7:0] e_crc,
                         input logic [7:0] e_r1, input logic e_tmo,
                         input logic [31:0] e_data,
                         input int e_polls);
    logic [7:0] exp_b [$];
    logic [7:0] got;
    logic       e_cs;
    int         d, nb, cyc, bad_m, bad_c, extra;
    d = fast ? DF : DS;
    for (int i = 0; i < nrsp; i++)
      resp[i] = rb[8 * (nrsp - 1 - i) +: 8];
    resp_len = nrsp;
    exp_b.push_back(8'hFF);
    exp_b.push_back({2'b01, idx});
    exp_b.push_back(arg[31:24]);
    exp_b.push_back(arg[23:16]);
    exp_b.push_back(arg[15:8]);
    exp_b.push_back(arg[7:0]);
    exp_b.push_back(e_crc);
    extra = e_polls + ((lng && !e_tmo) ? 4 : 0) + 1;
    for (int i = 0; i < extra; i++) exp_b.push_back(8'hFF);
    nb = exp_b.size();
    start_txn(1'b0, idx, arg, lng, fast);
    wait_rsp(cyc);
    check({tag, "_latency"}, cyc, nb * 8 * d + 1);
    check({tag, "_r1"}, rsp_r1, e_r1);
    check({tag, "_timeout"}, rsp_timeout, e_tmo);
    check({tag, "_data"}, rsp_data, e_data);
    after_rsp(tag);
    check({tag, "_held_r1"}, rsp_r1, e_r1);
    check({tag, "_sclk_count"}, nbits, nb * 8);
    bad_m = 0;
    bad_c = 0;
    for (int i = 0; i < nb * 8 && i < mosi_bits.size(); i++) begin
      e_cs = (i >= (nb - 1) * 8);
      if (mosi_bits[i] !== exp_b[i / 8][7 - (i % 8)]) bad_m++;
      if (cs_bits[i] !== e_cs) bad_c++;
    end
    check({tag, "_mosi_bad_bits"}, bad_m, 0);
    check({tag, "_cs_bad_bits"}, bad_c, 0);
    got = 8'hxx;
    if (mosi_bits.size() >= 56)
      for (int k = 0; k < 8; k++)
        got = {got[6:0], mosi_bits[48 + k]};
    check({tag, "_crc_byte"}, got, e_crc);
  endtask

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         lng;
    logic         fast;
    int           nrsp;
    logic [127:0] rsp;
    logic [7:0]   crc;
    logic [7:0]   r1;
    logic         tmo;
    logic [31:0]  data;
    int           polls;
  } vec_t;

  initial begin
    vec_t         tv [6];
    logic [7:0]   b [16];
    logic [127:0] rb;
    logic [5:0]   ridx;
    logic [31:0]  rarg, rdata;
    logic [7:0]   rr1;
    logic         rlng, rtmo;
    int           n, nlead, pos, polls, cyc, zm, zc, npulse;

    tv[0] = '{6'd0, 32'h0, 1'b0, 1'b0, 2, 128'hFF01,
              8'h95, 8'h01, 1'b0, 32'h0, 2};
    tv[1] = '{6'd8, 32'h1AA, 1'b1, 1'b1, 5, 128'h01000001AA,
              8'h87, 8'h01, 1'b0, 32'h1AA, 1};
    tv[2] = '{6'd55, 32'h0, 1'b0, 1'b1, 1, 128'h01,
              CRC55, 8'h01, 1'b0, 32'h0, 1};
    tv[3] = '{6'd41, 32'h40000000, 1'b0, 1'b1, 1, 128'h00,
              CRC41, 8'h00, 1'b0, 32'h0, 1};
    tv[4] = '{6'd8, 32'h1AA, 1'b1, 1'b1, 0, 128'h0,
              8'h87, 8'hFF, 1'b1, 32'h0, 8};
    tv[5] = '{6'd0, 32'h0, 1'b0, 1'b1, 8, 128'hFFFFFFFFFFFFFF05,
              8'h95, 8'h05, 1'b0, 32'h0, 8};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    cmd_long  = 1'b0;
    cmd_dummy = 1'b0;
    fast_clk  = 1'b0;
    sd_data   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_r1", rsp_r1, 8'hFF);
    check("rst_data", rsp_data, 0);
    check("rst_timeout", rsp_timeout, 0);
    check("rst_cclk", sd_cclk, 0);
    check("rst_cmd", sd_cmd, 1);
    check("rst_cs", sd_cs, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // power-up dummy clocks, slow divider
    resp_len = 0;
    start_txn(1'b1, 6'd5, 32'h12345678, 1'b1, 1'b0);
    check("dummy_cs_after_accept", sd_cs, 1);
    wait_rsp(cyc);
    check("dummy_latency", cyc, NDUM * 8 * DS + 1);
    check("dummy_r1", rsp_r1, 8'hFF);
    check("dummy_timeout", rsp_timeout, 0);
    after_rsp("dummy");
    check("dummy_pulses", nbits, NDUM * 8);
    zm = 0;
    zc = 0;
    for (int i = 0; i < mosi_bits.size(); i++) begin
      if (mosi_bits[i] !== 1'b1) zm++;
      if (cs_bits[i] !== 1'b1) zc++;
    end
    check("dummy_mosi_low_bits", zm, 0);
    check("dummy_cs_low_bits", zc, 0);

    for (int t = 0; t < 6; t++)
      run_cmd($sformatf("vec%0d", t), tv[t].idx, tv[t].arg,
              tv[t].lng, tv[t].fast, tv[t].nrsp, tv[t].rsp,
              tv[t].crc, tv[t].r1, tv[t].tmo, tv[t].data,
              tv[t].polls);

    for (int t = 0; t < 20; t++) begin
      ridx  = 6'($urandom);
      rarg  = $urandom;
      rlng  = 1'($urandom);
      nlead = $urandom_range(0, 9);
      n = 0;
      for (int i = 0; i < nlead; i++) begin
        b[n] = 8'($urandom) | 8'h80;
        n++;
      end
      b[n] = 8'($urandom) & 8'h7F;
      n++;
      for (int i = 0; i < 4; i++) begin
        b[n] = 8'($urandom);
        n++;
      end
      rb = '0;
      for (int i = 0; i < n; i++) rb = {rb[119:0], b[i]};
      pos = -1;
      for (int i = 0; i < PMAX && i < n; i++)
        if (pos < 0 && !b[i][7]) pos = i;
      rtmo  = (pos < 0);
      polls = rtmo ? PMAX : pos + 1;
      rr1   = rtmo ? 8'hFF : b[pos];
      rdata = '0;
      if (rlng && !rtmo)
        for (int k = 0; k < 4; k++)
          rdata = {rdata[23:0],
                   (pos + 1 + k < n) ? b[pos + 1 + k] : 8'hFF};
      run_cmd($sformatf("rnd%0d", t), ridx, rarg, rlng, 1'b1,
              n, rb, exp_crc(ridx, rarg), rr1, rtmo, rdata, polls);
    end

    // reset in the middle of the command bytes
    resp_len = 0;
    start_txn(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2000 && nbits < 35; i++) @(posedge clk);
    @(negedge clk);
    check("abort_cs_low_before", sd_cs, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", sd_cs, 1);
    check("abort_cclk", sd_cclk, 0);
    check("abort_cmd", sd_cmd, 1);
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (rsp_valid) npulse++;
    end
    check("abort_no_rsp", npulse, 0);
    run_cmd("post_reset", 6'd0, 32'h0, 1'b0, 1'b1, 1, 128'h01,
            8'h95, 8'h01, 1'b0, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
